// File: rtl/ram_access_sequencer.sv
// Turns mapper level strobes into single req/ack transactions to the memory controller.
// Define RAM_ACCESS_SEQUENCER_RFSH_FWD_EN to forward MSX refresh cycles as refresh requests.
module ram_access_sequencer #(
    parameter int ADDR_WIDTH = 23,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  OE_n,
    input  logic                  WE_n,
    input  logic [15:0]           DIN,
    input  logic                  DIN_SIZE,
    input  logic                  RFSH_n,
    output logic [15:0]           DOUT,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic                  MEM_RFSH,
    output logic [ADDR_WIDTH-2:0] MEM_ADDR,
    output logic [1:0]            MEM_BE,
    output logic [15:0]           MEM_DIN,
    input  logic                  MEM_ACK,
    input  logic [15:0]           MEM_DOUT,
    output logic                  BUSY,
    output logic                  TIMEOUT_ERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    typedef enum logic [1:0] {
        K_RD,
        K_WR,
        K_RF
    } kind_t;

    state_t                state_q;
    kind_t                 kind_q;
    logic [CW-1:0]         cnt_q;

    logic                  oe_prev_q;
    logic                  we_prev_q;

    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_size_q, rd_size_d;

    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_din_q, wr_din_d;
    logic                  wr_size_q, wr_size_d;

    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-2:0] addr_q;
    logic [1:0]            be_q;
    logic [15:0]           din_q;
    logic [15:0]           dout_q;
    logic                  err_q;

    logic                  rd_ev;
    logic                  wr_ev;
    logic                  to_hit;
    logic                  fin;

`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
    logic                  rf_prev_q;
    logic                  rf_pend_q, rf_pend_d;
    logic                  rf_ev;
    logic                  rfsh_q;
`else
    logic                  unused_rfsh;
`endif

    function automatic logic [1:0] lane_be(input logic a0, input logic sz);
        lane_be = sz ? 2'b11 : (a0 ? 2'b10 : 2'b01);
    endfunction

    assign to_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    // A finishing transaction clears its own flag first, so a same-type
    // event landing on the ACK edge survives as the next pending request.
    always_comb begin
        rd_ev     = oe_prev_q & ~OE_n;
        wr_ev     = we_prev_q & ~WE_n;
        fin       = (state_q == S_REQ) & (MEM_ACK | to_hit);

        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        rd_size_d = rd_size_q;
        if (fin && kind_q == K_RD) rd_pend_d = 1'b0;
        if (rd_ev) begin
            rd_pend_d = 1'b1;
            rd_addr_d = ADDR;
            rd_size_d = DIN_SIZE;
        end

        wr_pend_d = wr_pend_q;
        wr_addr_d = wr_addr_q;
        wr_din_d  = wr_din_q;
        wr_size_d = wr_size_q;
        if (fin && kind_q == K_WR) wr_pend_d = 1'b0;
        if (wr_ev) begin
            wr_pend_d = 1'b1;
            wr_addr_d = ADDR;
            wr_din_d  = DIN;
            wr_size_d = DIN_SIZE;
        end
    end

`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
    always_comb begin
        rf_ev     = rf_prev_q & ~RFSH_n;
        rf_pend_d = rf_pend_q;
        if (fin && kind_q == K_RF) rf_pend_d = 1'b0;
        if (rf_ev) rf_pend_d = 1'b1;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_RD;
            cnt_q     <= '0;
            oe_prev_q <= 1'b1;
            we_prev_q <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_size_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_din_q  <= '0;
            wr_size_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
            rf_prev_q <= 1'b1;
            rf_pend_q <= 1'b0;
            rfsh_q    <= 1'b0;
`endif
        end else begin
            oe_prev_q <= OE_n;
            we_prev_q <= WE_n;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            rd_size_q <= rd_size_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_din_q  <= wr_din_d;
            wr_size_q <= wr_size_d;
`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
            rf_prev_q <= RFSH_n;
            rf_pend_q <= rf_pend_d;
`endif
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (wr_pend_q) begin
                        state_q <= S_REQ;
                        kind_q  <= K_WR;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= wr_addr_q[ADDR_WIDTH-1:1];
                        be_q    <= lane_be(wr_addr_q[0], wr_size_q);
                        din_q   <= wr_size_q ? wr_din_q : {2{wr_din_q[7:0]}};
`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
                        rfsh_q  <= 1'b0;
`endif
                    end else if (rd_pend_q) begin
                        state_q <= S_REQ;
                        kind_q  <= K_RD;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= rd_addr_q[ADDR_WIDTH-1:1];
                        be_q    <= lane_be(rd_addr_q[0], rd_size_q);
`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
                        rfsh_q  <= 1'b0;
`endif
                    end
`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
                    else if (rf_pend_q) begin
                        state_q <= S_REQ;
                        kind_q  <= K_RF;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        be_q    <= 2'b00;
                        rfsh_q  <= 1'b1;
                    end
`endif
                end
                S_REQ: begin
                    if (MEM_ACK) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        if (kind_q == K_RD) dout_q <= MEM_DOUT;
                    end else if (to_hit) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MEM_REQ     = req_q;
    assign MEM_WE      = we_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_BE      = be_q;
    assign MEM_DIN     = din_q;
    assign DOUT        = dout_q;
    assign BUSY        = (state_q == S_REQ);
    assign TIMEOUT_ERR = err_q;

`ifdef RAM_ACCESS_SEQUENCER_RFSH_FWD_EN
    assign MEM_RFSH = rfsh_q;
`else
    assign MEM_RFSH    = 1'b0;
    assign unused_rfsh = RFSH_n;
`endif

endmodule

// File: doc/ram_access_sequencer.md
Name: ram_access_sequencer

Overview:
- Sits directly downstream of the MSX cartridge ROM/RAM mappers, on the device side of RAM_IF.
- Converts the mapper's level-style strobes (ADDR, OE_n, WE_n, DIN, DIN_SIZE, RFSH_n) into single request/acknowledge transactions toward the PSRAM/SDRAM memory controller.
- Returns read data to the mapper as a level that holds until the next read completes.
- Forwards MSX refresh cycles as memory refresh requests when enabled.

Parameters:
ADDR_WIDTH, 23, byte address width of ADDR and MEM_ADDR
TIMEOUT, 255, cycles waiting for MEM_ACK before the transaction is abandoned; 0 disables the timeout

Ports:
CLK  input  1  system clock
RESET_n  input  1  synchronous active-low reset
ADDR  input  ADDR_WIDTH  byte address from mapper
OE_n  input  1  read strobe, level, active low
WE_n  input  1  write strobe, level, active low
DIN  input  16  write data; byte in DIN[7:0] when 8-bit
DIN_SIZE  input  1  0 = 8-bit, 1 = 16-bit
RFSH_n  input  1  MSX refresh, level, active low
DOUT  output  16  read data to mapper, held
MEM_REQ  output  1  request to memory controller
MEM_WE  output  1  1 = write, 0 = read (valid with MEM_REQ)
MEM_RFSH  output  1  refresh request (valid with MEM_REQ)
MEM_ADDR  output  ADDR_WIDTH-1  word address
MEM_BE  output  2  byte enables
MEM_DIN  output  16  write data, byte lane aligned
MEM_ACK  input  1  one-cycle completion pulse
MEM_DOUT  input  16  read word, valid when MEM_ACK=1
BUSY  output  1  transaction outstanding
TIMEOUT_ERR  output  1  sticky timeout flag

Behaviour:
- Reset values (RESET_n sampled low at a CLK edge):
  - MEM_REQ=0, MEM_WE=0, MEM_RFSH=0, MEM_ADDR=0, MEM_BE=0, MEM_DIN=0
  - DOUT=0, BUSY=0, TIMEOUT_ERR=0
  - state=IDLE; pending flags cleared; previous-strobe registers set to 1
- Edge detection: registered previous OE_n/WE_n/RFSH_n. An event is prev=1 and now=0. A strobe held low continuously produces exactly one event.
- Pending capture:
  - Each event type sets a one-deep pending flag and captures ADDR/DIN/DIN_SIZE in the same cycle.
  - A second event of the same type while that flag is set overwrites the captured fields (last wins).
- Priority when several are pending in IDLE: write > read > refresh.
- States:
  - IDLE: no pending -> stay. Otherwise -> REQ with the highest-priority pending; MEM_REQ=1 and fields driven in the next cycle.
  - REQ: MEM_REQ=1; fields stable until MEM_ACK. On MEM_ACK -> IDLE in the next cycle: MEM_REQ=0, pending flag cleared. If the read flag is set, DOUT<=MEM_DOUT. A zero-wait ACK in the first REQ cycle is legal.
- BUSY=1 in REQ.
- Latency: event at edge N -> MEM_REQ=1 after edge N+1 -> DOUT updated at the edge after the MEM_ACK cycle.
- Timeout (TIMEOUT>0): a counter runs in REQ. When it reaches TIMEOUT without ACK -> IDLE, MEM_REQ=0, pending flag cleared, TIMEOUT_ERR=1 (cleared only by reset), DOUT unchanged.
- MEM_ACK outside REQ is ignored.
- Address and byte mapping:
  - MEM_ADDR = captured ADDR[ADDR_WIDTH-1:1].
  - 8-bit access: MEM_BE = ADDR[0] ? 2'b10 : 2'b01; MEM_DIN = {DIN[7:0], DIN[7:0]}.
  - 16-bit access: MEM_BE = 2'b11; MEM_DIN = DIN.
  - Refresh: MEM_BE=0, MEM_WE=0, MEM_RFSH=1.
- Reads: DOUT holds the full word. The mapper selects the byte. A strobe released before ACK still completes, and DOUT still updates.
- Reset mid-transaction: MEM_REQ drops at that edge; a subsequent late ACK is ignored.
- An event coincident with ACK of the same type is kept pending and issued next.

Optional Feature:
RAM_ACCESS_SEQUENCER_RFSH_FWD_EN:
- Defined: RFSH_n events generate refresh transactions as above.
- Undefined: RFSH_n is ignored; MEM_RFSH is tied 0; the refresh pending flag and its path are removed.

Test Plan:
- Reset, then OE_n falls with ADDR=0x012345, DIN_SIZE=0; controller ACKs 3 cycles after MEM_REQ with MEM_DOUT=0xA55A -> MEM_REQ=1 with MEM_WE=0, MEM_ADDR=0x0091A2, MEM_BE=2'b10; DOUT=0xA55A one cycle after ACK; BUSY returns 0.
- WE_n falls with ADDR=0x000100, DIN=0x0077, DIN_SIZE=0 while OE_n falls in the same cycle -> write issued first (MEM_WE=1, MEM_BE=2'b01, MEM_DIN=0x7777), then read; DOUT changes only after the read ACK.
- 16-bit write with ADDR=0x000200, DIN=0xBEEF -> MEM_BE=2'b11, MEM_DIN=0xBEEF, MEM_ADDR=0x000100.
- Macro defined: RFSH_n pulses low while idle -> one request with MEM_RFSH=1 and MEM_BE=0. Macro undefined: no request.
- TIMEOUT=8, no ACK -> MEM_REQ drops after 8 REQ cycles; TIMEOUT_ERR=1 and stays set; DOUT unchanged; a later ACK is ignored.
- RESET_n asserted 2 cycles into REQ, ACK arrives 1 cycle later -> all outputs at reset values; no DOUT update, no request reissued.
